// File: rtl/operand_rom_streamer.sv
// Clocked operand ROM that streams a single word or a wrapping burst over valid/ready.
// Optional build macro OPROM_TRISTATE_EN floats d whenever en is low.
module operand_rom_streamer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] addr_start,
  input  logic [ADDR_W-1:0] len,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] d,
  output logic              d_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] addr_inc;
  logic [DATA_W-1:0] d_q;
  logic              d_valid_q;
  logic              busy_q;
  logic              done_q;

  // Constant table; entries beyond 15 read zero, values zero-extended to DATA_W.
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [7:0] v;
    v = 8'd0;
    case (32'(a))
      32'd0:   v = 8'd5;
      32'd1:   v = 8'd7;
      32'd2:   v = 8'd14;
      32'd3:   v = 8'd15;
      32'd4:   v = 8'd31;
      32'd5:   v = 8'd55;
      32'd6:   v = 8'd87;
      32'd7:   v = 8'd63;
      32'd8:   v = 8'd48;
      32'd9:   v = 8'd50;
      32'd10:  v = 8'd49;
      32'd11:  v = 8'd54;
      32'd12:  v = 8'd47;
      32'd13:  v = 8'd144;
      32'd14:  v = 8'd104;
      32'd15:  v = 8'd105;
      default: v = 8'd0;
    endcase
    return DATA_W'(v);
  endfunction

  assign addr_inc = addr_q + ADDR_W'(1);

  // Control FSM; en low drops straight to idle without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      d_q       <= '0;
      d_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!en) begin
        state_q   <= S_IDLE;
        d_valid_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              addr_q  <= addr_start;
              cnt_q   <= mode ? len : '0;
              state_q <= S_LOAD;
              busy_q  <= 1'b1;
            end
          end
          S_LOAD: begin
            d_q       <= rom_word(addr_q);
            d_valid_q <= 1'b1;
            state_q   <= S_HOLD;
          end
          S_HOLD: begin
            if (rd_ready) begin
              if (cnt_q != '0) begin
                addr_q <= addr_inc;
                d_q    <= rom_word(addr_inc);
                cnt_q  <= cnt_q - ADDR_W'(1);
              end else begin
                d_valid_q <= 1'b0;
                done_q    <= 1'b1;
                busy_q    <= 1'b0;
                state_q   <= S_IDLE;
              end
            end
          end
          default: begin
            state_q   <= S_IDLE;
            d_valid_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef OPROM_TRISTATE_EN
  assign d = en ? d_q : {DATA_W{1'bz}};
`else
  assign d = d_q;
`endif
  assign d_valid = d_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
